// File: rtl/life_board_pkg.sv
// Board geometry and index helpers shared by the Game-of-Life datapath.
package life_board_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int POP_W = 10;

  // Row of a row-major cell index.
  function automatic int idx2row(input int idx);
    return idx / COLS;
  endfunction

  // Column of a row-major cell index.
  function automatic int idx2col(input int idx);
    return idx % COLS;
  endfunction

  // Step forward by one, wrapping n-1 back to 0 (toroidal board edge).
  function automatic int wrap_inc(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

  // Step back by one, wrapping 0 around to n-1 (toroidal board edge).
  function automatic int wrap_dec(input int v, input int n);
    return (v == 0) ? n - 1 : v - 1;
  endfunction

endpackage

// File: rtl/life_board_datapath_rule.sv
// Conway life rule for a single cell: survive on 2 or 3 neighbours, birth on exactly 3.
module life_cell_rule (
  input  logic       i_alive,
  input  logic [7:0] i_nbr,
  output logic       o_next
);

  logic [3:0] w_n;

  // Count live neighbours, then apply the birth/survival rule.
  always_comb begin
    w_n = '0;
    for (int i = 0; i < 8; i++) begin
      w_n = w_n + 4'(i_nbr[i]);
    end
    o_next = (w_n == 4'd3) || (i_alive && (w_n == 4'd2));
  end

endmodule

// File: rtl/life_board_datapath.sv
// Toroidal Game-of-Life board: serial load, one-cell-per-strobe evaluation, whole-board commit.
module life_board_datapath
  import life_board_pkg::*;
#(
  parameter int CNT_W = 9,
  parameter int GEN_W = 8
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              loadData,
  input  logic              inp,
  input  logic              readData,
  input  logic              writeData,
  input  logic [CNT_W-1:0]  count,
  output logic              cell_out,
  output logic              loseSig,
  output logic              stableSig,
  output logic [POP_W-1:0]  pop,
  output logic [GEN_W-1:0]  gen
);

  logic [CELLS-1:0] r_cur;
  logic [CELLS-1:0] r_nxt;
  logic             r_cell;
  logic             r_lose;
  logic             r_stable;
  logic [POP_W-1:0] r_pop;
  logic [GEN_W-1:0] r_gen;

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_nbr;
  logic             w_next;

  function automatic logic [POP_W-1:0] popcount(input logic [CELLS-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < CELLS; i++) begin
      s = s + POP_W'(v[i]);
    end
    return s;
  endfunction

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (v == '1) ? v : v + GEN_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] cell_at(input int r, input int c);
    return IDX_W'(r * COLS + c);
  endfunction

  assign w_in_range = (32'(count) < CELLS);
  assign w_idx      = IDX_W'(count);

  // Gather the eight wrapped neighbours of the addressed cell (order: NW N NE W E SW S SE).
  always_comb begin
    int r, c, rm, rp, cm, cp;
    r  = 0;
    c  = 0;
    if (w_in_range) begin
      r = idx2row(int'(count));
      c = idx2col(int'(count));
    end
    rm = wrap_dec(r, ROWS);
    rp = wrap_inc(r, ROWS);
    cm = wrap_dec(c, COLS);
    cp = wrap_inc(c, COLS);
    w_nbr[0] = r_cur[cell_at(rm, cm)];
    w_nbr[1] = r_cur[cell_at(rm, c )];
    w_nbr[2] = r_cur[cell_at(rm, cp)];
    w_nbr[3] = r_cur[cell_at(r,  cm)];
    w_nbr[4] = r_cur[cell_at(r,  cp)];
    w_nbr[5] = r_cur[cell_at(rp, cm)];
    w_nbr[6] = r_cur[cell_at(rp, c )];
    w_nbr[7] = r_cur[cell_at(rp, cp)];
  end

  life_cell_rule u_rule (
    .i_alive (r_cur[w_idx]),
    .i_nbr   (w_nbr),
    .o_next  (w_next)
  );

  // Board state and status flags; loadData beats writeData beats readData.
  always_ff @(posedge clka) begin
    if (restart) begin
      r_cur    <= '0;
      r_nxt    <= '0;
      r_cell   <= 1'b0;
      r_lose   <= 1'b0;
      r_stable <= 1'b0;
      r_gen    <= '0;
    end else if (loadData) begin
      if (w_in_range) begin
        r_cur[w_idx] <= inp;
        r_gen        <= '0;
        r_lose       <= 1'b0;
        r_stable     <= 1'b0;
      end
    end else if (writeData) begin
      r_cur    <= r_nxt;
      r_lose   <= (r_nxt == '0);
      r_stable <= (r_nxt == r_cur);
      r_gen    <= sat_inc(r_gen);
    end else if (readData && w_in_range) begin
      r_nxt[w_idx] <= w_next;
      r_cell       <= r_cur[w_idx];
    end
  end

  // Population trails the board by one cycle so the popcount sits behind its own register.
  always_ff @(posedge clka) begin
    if (restart) begin
      r_pop <= '0;
    end else begin
      r_pop <= popcount(r_cur);
    end
  end

  assign cell_out  = r_cell;
  assign loseSig   = r_lose;
  assign stableSig = r_stable;
  assign pop       = r_pop;
  assign gen       = r_gen;

endmodule

// File: tb/tb_life_board_datapath.sv
// Scoreboard bench for life_board_datapath: directed board patterns with hand-derived results.
module tb_life_board_datapath;

  localparam int S_CELL = 0, S_LOSE = 1, S_STAB = 2, S_POP = 3, S_GEN = 4;

  logic       clka = 1'b0;
  logic       restart, loadData, inp, readData, writeData;
  logic [8:0] count;
  logic       cell_out, loseSig, stableSig;
  logic [9:0] pop;
  logic [7:0] gen;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clka = ~clka;

  life_board_datapath #(.CNT_W(9), .GEN_W(8)) dut (
    .clka      (clka),
    .restart   (restart),
    .loadData  (loadData),
    .inp       (inp),
    .readData  (readData),
    .writeData (writeData),
    .count     (count),
    .cell_out  (cell_out),
    .loseSig   (loseSig),
    .stableSig (stableSig),
    .pop       (pop),
    .gen       (gen)
  );

  // Monitor: on each falling edge, compare every pending expectation against the DUT.
  exp_t mon_e;
  int   mon_act;
  always @(negedge clka) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        S_CELL:  mon_act = int'(cell_out);
        S_LOSE:  mon_act = int'(loseSig);
        S_STAB:  mon_act = int'(stableSig);
        S_POP:   mon_act = int'(pop);
        default: mon_act = int'(gen);
      endcase
      total++;
      if (mon_act !== mon_e.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic expect_out(input string name, input int sel, input int val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = val;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic load(input int idx, input logic b);
    count    = 9'(idx);
    inp      = b;
    loadData = 1'b1;
    tick();
    loadData = 1'b0;
  endtask

  task automatic rd(input int idx);
    count    = 9'(idx);
    readData = 1'b1;
    tick();
    readData = 1'b0;
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) rd(i);
  endtask

  task automatic commit();
    writeData = 1'b1;
    tick();
    writeData = 1'b0;
  endtask

  task automatic expect_all_zero(input string tag);
    expect_out({tag, "_cell"},   S_CELL, 0);
    expect_out({tag, "_lose"},   S_LOSE, 0);
    expect_out({tag, "_stable"}, S_STAB, 0);
    expect_out({tag, "_pop"},    S_POP,  0);
    expect_out({tag, "_gen"},    S_GEN,  0);
  endtask

  initial begin
    restart = 1'b0; loadData = 1'b0; inp = 1'b0;
    readData = 1'b0; writeData = 1'b0; count = '0;

    // Reset state
    do_reset();
    expect_all_zero("reset");

    // Blinker: horizontal row 3 cols 2..4 -> vertical col 3 rows 2..4 -> horizontal again
    load(26, 1'b1); load(27, 1'b1); load(28, 1'b1);
    tick();
    expect_out("blink_pop_loaded", S_POP, 3);
    expect_out("blink_gen_loaded", S_GEN, 0);
    sweep(0, 63);
    commit();
    expect_out("blink_gen1",    S_GEN,  1);
    expect_out("blink_stable1", S_STAB, 0);
    expect_out("blink_lose1",   S_LOSE, 0);
    tick();
    expect_out("blink_pop1", S_POP, 3);
    rd(19); expect_out("blink_c19", S_CELL, 1);
    rd(26); expect_out("blink_c26", S_CELL, 0);
    rd(27); expect_out("blink_c27", S_CELL, 1);
    rd(28); expect_out("blink_c28", S_CELL, 0);
    rd(35); expect_out("blink_c35", S_CELL, 1);
    sweep(0, 63);
    commit();
    expect_out("blink_gen2",    S_GEN,  2);
    expect_out("blink_stable2", S_STAB, 0);
    rd(26); expect_out("blink2_c26", S_CELL, 1);
    rd(19); expect_out("blink2_c19", S_CELL, 0);
    rd(28); expect_out("blink2_c28", S_CELL, 1);

    // Block in the corner stays put on the torus
    do_reset();
    load(0, 1'b1); load(1, 1'b1); load(8, 1'b1); load(9, 1'b1);
    sweep(0, 63);
    commit();
    expect_out("block_stable", S_STAB, 1);
    expect_out("block_lose",   S_LOSE, 0);
    expect_out("block_gen",    S_GEN,  1);
    tick();
    expect_out("block_pop", S_POP, 4);

    // Lone cell dies -> extinction; reload clears flags and generation
    do_reset();
    load(27, 1'b1);
    tick();
    expect_out("lone_pop_loaded", S_POP, 1);
    sweep(0, 63);
    commit();
    expect_out("lone_lose",   S_LOSE, 1);
    expect_out("lone_stable", S_STAB, 0);
    tick();
    expect_out("lone_pop_dead", S_POP, 0);
    load(0, 1'b1);
    expect_out("reload_lose", S_LOSE, 0);
    expect_out("reload_gen",  S_GEN,  0);
    tick();
    expect_out("reload_pop", S_POP, 1);

    // Toroidal wrap: corners 7, 56, 63 give cell 0 exactly three neighbours
    do_reset();
    load(7, 1'b1); load(56, 1'b1); load(63, 1'b1);
    rd(0);
    expect_out("wrap_cell_out", S_CELL, 0);
    commit();
    expect_out("wrap_lose", S_LOSE, 0);
    tick();
    expect_out("wrap_pop", S_POP, 1);
    rd(0);
    expect_out("wrap_nxt0", S_CELL, 1);

    // Simultaneous strobes: only the load takes effect
    do_reset();
    count = 9'd5; inp = 1'b1;
    loadData = 1'b1; writeData = 1'b1; readData = 1'b1;
    tick();
    loadData = 1'b0; writeData = 1'b0; readData = 1'b0;
    expect_out("prio_gen",  S_GEN,  0);
    expect_out("prio_cell", S_CELL, 0);
    expect_out("prio_lose", S_LOSE, 0);
    tick();
    expect_out("prio_pop", S_POP, 1);
    rd(5);
    expect_out("prio_cur5", S_CELL, 1);
    load(64, 1'b1);
    tick();
    expect_out("oob_load_pop", S_POP, 1);
    rd(64);
    expect_out("oob_read_cell", S_CELL, 1);

    // Generation counter saturates at 255
    for (int i = 0; i < 255; i++) commit();
    expect_out("gen_at_max", S_GEN, 255);
    commit();
    expect_out("gen_saturated", S_GEN, 255);

    // Restart mid-sweep discards the partial next generation
    do_reset();
    load(26, 1'b1); load(27, 1'b1); load(28, 1'b1);
    sweep(0, 63);
    commit();
    sweep(0, 30);
    rd(27);
    expect_out("mid_cell_before", S_CELL, 1);
    expect_out("mid_gen_before",  S_GEN,  1);
    do_reset();
    expect_all_zero("mid_reset");
    commit();
    expect_out("mid_commit_lose",   S_LOSE, 1);
    expect_out("mid_commit_stable", S_STAB, 1);
    expect_out("mid_commit_gen",    S_GEN,  1);

    tick();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
